// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the immediate-generation stage.
package imm_gen_pkg;

    localparam int unsigned INST_W         = 32;
    localparam int unsigned FMT_W          = 3;
    localparam int unsigned RVC_LEN        = 16;
    localparam int unsigned IMM_FIFO_DEPTH = 2;
    localparam int unsigned CNT_W          = $clog2(IMM_FIFO_DEPTH + 1);

    typedef enum logic [FMT_W-1:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_Z  = 3'd5,
        IMM_CI = 3'd6,
        IMM_CJ = 3'd7
    } imm_fmt_t;

    // Per-entry sideband stored alongside the immediate.
    typedef struct packed {
        imm_fmt_t fmt;
        logic     illegal;
    } imm_meta_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: (instruction, format) -> extended immediate + illegal flag.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          EN_RVC = 1'b1
) (
    input  logic [INST_W-1:0] inst,
    input  imm_fmt_t          fmt,
    output logic [XLEN-1:0]   imm,
    output logic              illegal
);

    logic [RVC_LEN-1:0] cinst;
    logic [31:0]        imm32;
    logic               unused_cinst_bits;

    assign cinst             = inst[RVC_LEN-1:0];
    assign unused_cinst_bits = ^{cinst[15:13], cinst[1:0]};

    // Every format fits in 32 bits; widen once at the end.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (fmt)
            IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm32 = {inst[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z: imm32 = {27'b0, inst[19:15]};
            IMM_CI: begin
                if (EN_RVC) begin
                    imm32 = {{26{cinst[12]}}, cinst[12], cinst[6:2]};
                end else begin
                    illegal = 1'b1;
                end
            end
            IMM_CJ: begin
                if (EN_RVC) begin
                    imm32 = {{20{cinst[12]}}, cinst[12], cinst[8], cinst[10:9], cinst[6],
                             cinst[7], cinst[2], cinst[11], cinst[5:3], 1'b0};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: imm32 = '0;
        endcase
    end

    // Z has bit 31 clear, so the common sign extension also zero-extends it.
    assign imm = XLEN'({{32{imm32[31]}}, imm32});

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: extracts the immediate at the input and
// buffers it in a 2-entry skid FIFO with valid/ready handshake and flush.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          EN_RVC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [FMT_W-1:0]  in_fmt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [FMT_W-1:0]  out_fmt,
    output logic              out_illegal
);

    logic [XLEN-1:0]  new_imm_c;
    logic             new_illegal_c;
    imm_meta_t        new_meta_c;

    logic [CNT_W-1:0] count_q,     count_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  head_imm_q,  head_imm_d;
    imm_meta_t        head_meta_q, head_meta_d;
    logic [XLEN-1:0]  tail_imm_q,  tail_imm_d;
    imm_meta_t        tail_meta_q, tail_meta_d;

    logic             push_c;
    logic             pop_c;

    imm_extract #(
        .XLEN   (XLEN),
        .EN_RVC (EN_RVC)
    ) u_extract (
        .inst    (in_inst),
        .fmt     (imm_fmt_t'(in_fmt)),
        .imm     (new_imm_c),
        .illegal (new_illegal_c)
    );

    assign new_meta_c = '{fmt: imm_fmt_t'(in_fmt), illegal: new_illegal_c};

    // in_ready is a registered flag, so accepting never depends on out_ready this cycle.
    assign push_c = in_valid & in_ready_q & ~flush;
    assign pop_c  = out_valid_q & out_ready;

    // Head is always the presented entry; tail only fills while head is stalled.
    always_comb begin
        count_d     = count_q;
        head_imm_d  = head_imm_q;
        head_meta_d = head_meta_q;
        tail_imm_d  = tail_imm_q;
        tail_meta_d = tail_meta_q;

        if (flush) begin
            count_d     = '0;
            head_imm_d  = '0;
            head_meta_d = '0;
            tail_imm_d  = '0;
            tail_meta_d = '0;
        end else begin
            if (pop_c) begin
                if (count_q == CNT_W'(IMM_FIFO_DEPTH)) begin
                    head_imm_d  = tail_imm_q;
                    head_meta_d = tail_meta_q;
                    tail_imm_d  = '0;
                    tail_meta_d = '0;
                end else if (push_c) begin
                    head_imm_d  = new_imm_c;
                    head_meta_d = new_meta_c;
                end else begin
                    head_imm_d  = '0;
                    head_meta_d = '0;
                end
            end else if (push_c) begin
                if (count_q == '0) begin
                    head_imm_d  = new_imm_c;
                    head_meta_d = new_meta_c;
                end else begin
                    tail_imm_d  = new_imm_c;
                    tail_meta_d = new_meta_c;
                end
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end

        in_ready_d  = (count_d != CNT_W'(IMM_FIFO_DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_imm_q  <= '0;
            head_meta_q <= '0;
            tail_imm_q  <= '0;
            tail_meta_q <= '0;
        end else begin
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_imm_q  <= head_imm_d;
            head_meta_q <= head_meta_d;
            tail_imm_q  <= tail_imm_d;
            tail_meta_q <= tail_meta_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = head_imm_q;
    assign out_fmt     = head_meta_q.fmt;
    assign out_illegal = head_meta_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three configurations share one stimulus stream and are
// checked each cycle against a queue-based reference plus hand-computed literals.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [2:0]  in_fmt;

    logic        ir32, ov32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ir64, ov64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        irnr, ovnr, illnr;
    logic [31:0] immnr;
    logic [2:0]  fmtnr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .EN_RVC(1'b1)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .in_inst(in_inst), .in_fmt(in_fmt), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32));

    imm_gen_stage #(.XLEN(64), .EN_RVC(1'b1)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .in_inst(in_inst), .in_fmt(in_fmt), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64));

    imm_gen_stage #(.XLEN(32), .EN_RVC(1'b0)) dutnr (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irnr),
        .in_inst(in_inst), .in_fmt(in_fmt), .out_valid(ovnr), .out_ready(out_ready),
        .out_imm(immnr), .out_fmt(fmtnr), .out_illegal(illnr));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference immediate built from bit-field arithmetic on the instruction.
    function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
        return longint'({32'b0, x} >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sx(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [2:0] f, input bit rvc);
        longint v = 0;
        bit     ill = 0;
        case (f)
            3'd0: v = sx(fld(i, 31, 20), 12);
            3'd1: v = sx((fld(i, 31, 25) << 5) | fld(i, 11, 7), 12);
            3'd2: v = sx((fld(i, 31, 31) << 12) | (fld(i, 7, 7) << 11) |
                         (fld(i, 30, 25) << 5) | (fld(i, 11, 8) << 1), 13);
            3'd3: v = sx(fld(i, 31, 12) << 12, 32);
            3'd4: v = sx((fld(i, 31, 31) << 20) | (fld(i, 19, 12) << 12) |
                         (fld(i, 20, 20) << 11) | (fld(i, 30, 21) << 1), 21);
            3'd5: v = fld(i, 19, 15);
            3'd6: if (rvc) v = sx((fld(i, 12, 12) << 5) | fld(i, 6, 2), 6); else ill = 1;
            default: begin
                if (rvc) v = sx((fld(i, 12, 12) << 11) | (fld(i, 11, 11) << 4) |
                                (fld(i, 10, 9) << 8) | (fld(i, 8, 8) << 10) |
                                (fld(i, 7, 7) << 6) | (fld(i, 6, 6) << 7) |
                                (fld(i, 5, 3) << 1) | (fld(i, 2, 2) << 5), 12);
                else ill = 1;
            end
        endcase
        return {ill, 64'(v)};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
    } ent_t;

    ent_t mq[$];

    // Reference FIFO occupancy.
    always @(posedge clk or posedge reset) begin
        bit   push_m, pop_m;
        ent_t e;
        if (reset) begin
            mq.delete();
        end else begin
            push_m = in_valid && (mq.size() < 2) && !flush;
            pop_m  = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (push_m) begin
                    e.inst = in_inst;
                    e.fmt  = in_fmt;
                    mq.push_back(e);
                end
            end
        end
    end

    // Per-cycle compare of all three instances against the reference.
    always @(negedge clk) begin
        logic [64:0] e_rvc, e_nr;
        logic [2:0]  e_fmt;
        bit          hv;
        hv    = mq.size() > 0;
        e_rvc = '0;
        e_nr  = '0;
        e_fmt = '0;
        if (hv) begin
            e_rvc = ref_imm(mq[0].inst, mq[0].fmt, 1'b1);
            e_nr  = ref_imm(mq[0].inst, mq[0].fmt, 1'b0);
            e_fmt = mq[0].fmt;
        end
        chk("ready32",  64'(ir32),  64'(mq.size() < 2));
        chk("valid32",  64'(ov32),  64'(hv));
        chk("imm32",    64'(imm32), 64'(e_rvc[31:0]));
        chk("fmt32",    64'(fmt32), 64'(e_fmt));
        chk("ill32",    64'(ill32), 64'(e_rvc[64]));
        chk("ready64",  64'(ir64),  64'(mq.size() < 2));
        chk("valid64",  64'(ov64),  64'(hv));
        chk("imm64",    imm64,      e_rvc[63:0]);
        chk("fmt64",    64'(fmt64), 64'(e_fmt));
        chk("ill64",    64'(ill64), 64'(e_rvc[64]));
        chk("readynr",  64'(irnr),  64'(mq.size() < 2));
        chk("validnr",  64'(ovnr),  64'(hv));
        chk("immnr",    64'(immnr), 64'(e_nr[31:0]));
        chk("fmtnr",    64'(fmtnr), 64'(e_fmt));
        chk("illnr",    64'(illnr), 64'(e_nr[64]));
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] f);
        in_valid = v;
        in_inst  = inst;
        in_fmt   = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] tbl [5];
        tbl[0] = 32'h1234_5678;
        tbl[1] = 32'hFEDC_BA98;
        tbl[2] = 32'h8000_0001;
        tbl[3] = 32'h7FFF_FFFF;
        tbl[4] = 32'h0000_A5A5;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_fmt = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ov32), 64'd0);
        chk("rst_ready", 64'(ir32), 64'd1);
        chk("rst_imm",   imm64,     64'd0);
        reset = 1'b0;

        // Literal expectations from hand-decoded instructions.
        drive(1'b1, 32'hFFF0_0093, 3'd0);
        chk("addi_imm32", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
        chk("addi_imm64", imm64,      64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_valid", 64'(ov32),  64'd1);
        drive(1'b1, 32'h8000_02B7, 3'd3);
        chk("lui_imm64",  imm64,      64'hFFFF_FFFF_8000_0000);
        chk("lui_fmt",    64'(fmt64), 64'd3);
        drive(1'b1, 32'h000F_D073, 3'd5);
        chk("zimm_imm64", imm64,      64'h0000_0000_0000_001F);
        drive(1'b1, 32'h0000_BFF5, 3'd7);
        chk("cj_imm32",   64'(imm32), 64'h0000_0000_FFFF_FFFC);
        chk("cj_ill32",   64'(ill32), 64'd0);
        chk("cj_immnr",   64'(immnr), 64'd0);
        chk("cj_illnr",   64'(illnr), 64'd1);
        drive(1'b1, 32'h0000_107D, 3'd6);
        chk("ci_imm32",   64'(imm32), 64'h0000_0000_FFFF_FFFF);

        // Sweep every format over a few patterns with intermittent back-pressure.
        for (int k = 0; k < 40; k++) begin
            out_ready = (k % 3) != 2;
            drive(1'b1, tbl[k / 8], 3'(k % 8));
        end
        out_ready = 1'b1;
        repeat (3) drive(1'b0, '0, '0);

        // Back-pressure: two entries fill the stage, the third waits upstream.
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 3'd0);
        chk("bp_ready1", 64'(ir32), 64'd1);
        drive(1'b1, 32'h0020_0093, 3'd0);
        chk("bp_ready2", 64'(ir32), 64'd0);
        drive(1'b1, 32'h0030_0093, 3'd0);
        chk("bp_stall1", 64'(imm32), 64'd1);
        drive(1'b1, 32'h0030_0093, 3'd0);
        chk("bp_stall2", 64'(imm32), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'h0030_0093, 3'd0);
        chk("bp_drain2", 64'(imm32), 64'd2);
        drive(1'b1, 32'h0030_0093, 3'd0);
        chk("bp_drain3", 64'(imm32), 64'd3);
        drive(1'b0, '0, '0);
        chk("bp_empty",  64'(ov32),  64'd0);

        // Flush while full, with a new input offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h0050_0093, 3'd0);
        drive(1'b1, 32'h0060_0093, 3'd0);
        flush = 1'b1;
        drive(1'b1, 32'h0070_0093, 3'd0);
        flush = 1'b0;
        chk("fl_valid", 64'(ov32),  64'd0);
        chk("fl_ready", 64'(ir32),  64'd1);
        chk("fl_imm",   64'(imm32), 64'd0);
        out_ready = 1'b1;
        repeat (3) drive(1'b0, '0, '0);
        chk("fl_gone",  64'(ov32),  64'd0);

        // Asynchronous reset in the middle of a cycle with one entry held.
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_02B7, 3'd3);
        chk("ar_valid_pre", 64'(ov64), 64'd1);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(ov64),  64'd0);
        chk("ar_imm",   imm64,      64'd0);
        chk("ar_fmt",   64'(fmt64), 64'd0);
        chk("ar_ready", 64'(ir64),  64'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_ready_post", 64'(ir32), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF0_0093, 3'd0);
        chk("ar_resume", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
        repeat (3) drive(1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
